// File: rtl/prio_queue_pkg.sv
// -----------------------------------------------------------------------------
// prio_queue_pkg
// Shared types and constants for the priority queue.
//   PW / IW / EW : priority, ID and total entry widths
//   entry_t      : {prio, id} as it appears on the in/out ports
//   ENQ / DEQ    : encoding of the ende operation select
//   sel_e        : per-slot next-value selection used by prio_queue_cell
// -----------------------------------------------------------------------------
package prio_queue_pkg;

   localparam int PW = 2;
   localparam int IW = 2;
   localparam int EW = PW + IW;

   typedef struct packed {
      logic [PW-1:0] prio;
      logic [IW-1:0] id;
   } entry_t;

   localparam logic ENQ = 1'b0;
   localparam logic DEQ = 1'b1;

   typedef enum logic [1:0] {
      SEL_HOLD = 2'd0,
      SEL_NEW  = 2'd1,
      SEL_UP   = 2'd2,
      SEL_LO   = 2'd3
   } sel_e;

endpackage

// File: rtl/prio_queue_cell.sv
// -----------------------------------------------------------------------------
// prio_queue_cell
// One slot of the sorted queue. Holds a valid bit and an entry, reports whether
// the incoming entry outranks it, and picks its next contents.
//   clk, rst_n              : clock, async active-low reset (clears valid only)
//   i_enq / i_deq           : accepted enqueue / accepted dequeue this cycle
//   i_ins                   : this slot is the insertion point
//   i_shift_dn              : insertion point is above this slot
//   i_new                   : entry being enqueued
//   i_up_valid/i_up_entry   : neighbour closer to the head
//   i_lo_valid/i_lo_entry   : neighbour further from the head
//   o_valid/o_entry         : slot contents
//   o_lt                    : slot is empty or holds a strictly lower priority
// -----------------------------------------------------------------------------
module prio_queue_cell
   import prio_queue_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_enq,
   input  logic   i_deq,
   input  logic   i_ins,
   input  logic   i_shift_dn,
   input  entry_t i_new,
   input  logic   i_up_valid,
   input  entry_t i_up_entry,
   input  logic   i_lo_valid,
   input  entry_t i_lo_entry,
   output logic   o_valid,
   output entry_t o_entry,
   output logic   o_lt
);

   logic   r_valid;
   entry_t r_entry;
   sel_e   w_sel;

   // Strict compare keeps equal priorities in arrival order.
   assign o_lt    = !r_valid || (r_entry.prio < i_new.prio);
   assign o_valid = r_valid;
   assign o_entry = r_entry;

   always_comb begin
      w_sel = SEL_HOLD;
      if (i_deq) begin
         w_sel = SEL_LO;
      end else if (i_enq) begin
         if (i_ins) begin
            w_sel = SEL_NEW;
         end else if (i_shift_dn) begin
            w_sel = SEL_UP;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
      end else begin
         case (w_sel)
            SEL_NEW:  r_valid <= 1'b1;
            SEL_UP:   r_valid <= i_up_valid;
            SEL_LO:   r_valid <= i_lo_valid;
            default:  r_valid <= r_valid;
         endcase
      end
   end

   // Entry payload is qualified by r_valid, so it needs no reset.
   always_ff @(posedge clk) begin
      case (w_sel)
         SEL_NEW:  r_entry <= i_new;
         SEL_UP:   r_entry <= i_up_entry;
         SEL_LO:   r_entry <= i_lo_entry;
         default:  r_entry <= r_entry;
      endcase
   end

endmodule

// File: rtl/prio_queue.sv
// -----------------------------------------------------------------------------
// prio_queue
// Sorted-array priority queue of {prio, id} entries. Slot 0 is the head.
// Each clock either enqueues (ende=0) or dequeues (ende=1).
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in        : entry to enqueue {prio, id}
//   ende      : 0 = enqueue, 1 = dequeue
//   out       : last dequeued entry, held until the next successful dequeue
//   out_valid : high for the cycle after a successful dequeue
//   full      : DEPTH entries held
//   empty     : no entries held
// -----------------------------------------------------------------------------
module prio_queue
   import prio_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [EW-1:0] in,
   input  logic          ende,
   output logic [EW-1:0] out,
   output logic          out_valid,
   output logic          full,
   output logic          empty
);

   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   entry_t          w_new;
   entry_t          w_entry [DEPTH];
   logic [DEPTH-1:0] w_valid;
   logic [DEPTH-1:0] w_lt;
   logic [DEPTH-1:0] w_ins;
   logic [DEPTH-1:0] w_shift_dn;
   logic            w_enq_ok;
   logic            w_deq_ok;

   logic [CW-1:0]   r_count;
   entry_t          r_out;
   logic            r_out_valid;

   assign w_new = entry_t'(in);

   // An unknown ende falls to the else branch and is handled as an enqueue.
   always_comb begin
      w_enq_ok = 1'b0;
      w_deq_ok = 1'b0;
      if (ende == DEQ) begin
         w_deq_ok = !empty;
      end else begin
         w_enq_ok = !full;
      end
   end

   // The queue is sorted and packed toward slot 0, so w_lt is a thermometer
   // code; its first set bit is the insertion point and every slot below it
   // takes its upper neighbour.
   always_comb begin
      w_ins[0]      = w_lt[0];
      w_shift_dn[0] = 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
         w_ins[i]      = w_lt[i] & ~w_lt[i-1];
         w_shift_dn[i] = w_lt[i-1];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      logic   w_up_valid;
      entry_t w_up_entry;
      logic   w_lo_valid;
      entry_t w_lo_entry;

      if (g == 0) begin : g_head
         assign w_up_valid = 1'b0;
         assign w_up_entry = '0;
      end else begin : g_mid_up
         assign w_up_valid = w_valid[g-1];
         assign w_up_entry = w_entry[g-1];
      end

      if (g == DEPTH - 1) begin : g_tail
         assign w_lo_valid = 1'b0;
         assign w_lo_entry = '0;
      end else begin : g_mid_lo
         assign w_lo_valid = w_valid[g+1];
         assign w_lo_entry = w_entry[g+1];
      end

      prio_queue_cell u_cell (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_enq      (w_enq_ok),
         .i_deq      (w_deq_ok),
         .i_ins      (w_ins[g]),
         .i_shift_dn (w_shift_dn[g]),
         .i_new      (w_new),
         .i_up_valid (w_up_valid),
         .i_up_entry (w_up_entry),
         .i_lo_valid (w_lo_valid),
         .i_lo_entry (w_lo_entry),
         .o_valid    (w_valid[g]),
         .o_entry    (w_entry[g]),
         .o_lt       (w_lt[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (w_deq_ok) begin
         r_count <= r_count - CW'(1);
      end else if (w_enq_ok) begin
         r_count <= r_count + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= w_deq_ok;
         if (w_deq_ok) begin
            r_out <= w_entry[0];
         end
      end
   end

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign full      = (r_count == CNT_MAX);
   assign empty     = (r_count == '0);

endmodule

// File: tb/tb_prio_queue.sv
module tb_prio_queue;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] in;
   logic       ende;
   logic [3:0] out;
   logic       out_valid;
   logic       full;
   logic       empty;

   int checks = 0;
   int errors = 0;

   prio_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in),
      .ende      (ende),
      .out       (out),
      .out_valid (out_valid),
      .full      (full),
      .empty     (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model: arrival-stamped pool ----------------
   typedef struct {
      logic [3:0] e;
      int         seq;
   } mentry_t;

   mentry_t    mq[$];
   int         mseq = 0;
   logic [3:0] mout = 4'b0000;
   logic       mvld = 1'b0;

   task automatic model_reset();
      mq.delete();
      mout = 4'b0000;
      mvld = 1'b0;
   endtask

   // Dequeue picks the highest priority; among equals, the earliest arrival.
   task automatic model_op(input logic d, input logic [3:0] v);
      mentry_t ne;
      int      b;
      if (!d) begin
         mvld = 1'b0;
         if (mq.size() < DEPTH) begin
            ne.e   = v;
            ne.seq = mseq;
            mseq++;
            mq.push_back(ne);
         end
      end else begin
         if (mq.size() == 0) begin
            mvld = 1'b0;
         end else begin
            b = 0;
            for (int k = 1; k < mq.size(); k++) begin
               if ((mq[k].e[3:2] > mq[b].e[3:2]) ||
                   ((mq[k].e[3:2] == mq[b].e[3:2]) && (mq[k].seq < mq[b].seq)))
                  b = k;
            end
            mout = mq[b].e;
            mvld = 1'b1;
            mq.delete(b);
         end
      end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic d, input logic [3:0] v);
      ende = d;
      in   = v;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       d;
      logic [3:0] v;
      logic [3:0] eo;
      logic       ev;
      logic       ee;
      logic       ef;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic d, input logic [3:0] v, input logic [3:0] eo,
                      input logic ev, input logic ee, input logic ef);
      vec_t r;
      r.d = d; r.v = v; r.eo = eo; r.ev = ev; r.ee = ee; r.ef = ef;
      vt.push_back(r);
   endtask

   initial begin
      // Directed vectors: {ende, in, out, out_valid, empty, full} after the edge.
      // Two entries, dequeued by priority.
      add(0, 4'b1111, 4'b0000, 0, 0, 0);
      add(0, 4'b1010, 4'b0000, 0, 0, 0);
      add(1, 4'b0000, 4'b1111, 1, 0, 0);
      add(1, 4'b0000, 4'b1010, 1, 1, 0);
      // Priority first, FIFO among equal priority.
      add(0, 4'b0001, 4'b1010, 0, 0, 0);
      add(0, 4'b1110, 4'b1010, 0, 0, 0);
      add(0, 4'b0110, 4'b1010, 0, 0, 0);
      add(0, 4'b1111, 4'b1010, 0, 0, 1);
      add(1, 4'b0000, 4'b1110, 1, 0, 0);
      add(1, 4'b0000, 4'b1111, 1, 0, 0);
      add(1, 4'b0000, 4'b0110, 1, 0, 0);
      add(1, 4'b0000, 4'b0001, 1, 1, 0);
      // Fill with equal priority, overflow dropped, FIFO drain.
      add(0, 4'b0100, 4'b0001, 0, 0, 0);
      add(0, 4'b0101, 4'b0001, 0, 0, 0);
      add(0, 4'b0110, 4'b0001, 0, 0, 0);
      add(0, 4'b0111, 4'b0001, 0, 0, 1);
      add(0, 4'b1111, 4'b0001, 0, 0, 1);
      add(1, 4'b0000, 4'b0100, 1, 0, 0);
      add(1, 4'b0000, 4'b0101, 1, 0, 0);
      add(1, 4'b0000, 4'b0110, 1, 0, 0);
      add(1, 4'b0000, 4'b0111, 1, 1, 0);
      // Dequeue on empty keeps the held output.
      add(0, 4'b1010, 4'b0111, 0, 0, 0);
      add(1, 4'b0000, 4'b1010, 1, 1, 0);
      add(1, 4'b0000, 4'b1010, 0, 1, 0);
      add(1, 4'b0000, 4'b1010, 0, 1, 0);
      // Enqueue after a dequeue clears out_valid; duplicate IDs are accepted.
      add(0, 4'b1001, 4'b1010, 0, 0, 0);
      add(0, 4'b1101, 4'b1010, 0, 0, 0);
      add(1, 4'b0000, 4'b1101, 1, 0, 0);
      add(1, 4'b0000, 4'b1001, 1, 1, 0);

      // Reset state.
      rst_n = 1'b0;
      ende  = 1'b1;
      in    = 4'b0000;
      #12;
      chk("rst_out",       out,       4'b0000);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_empty",     empty,     1'b1);
      chk("rst_full",      full,      1'b0);
      #1 rst_n = 1'b1;
      step(1'b1, 4'b0000);
      chk("rel_deq_empty",     empty,     1'b1);
      chk("rel_deq_out_valid", out_valid, 1'b0);
      chk("rel_deq_out",       out,       4'b0000);

      // Table-driven directed sequences.
      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].d, vt[i].v);
         chk($sformatf("vec%0d_out", i),       out,       vt[i].eo);
         chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].ev);
         chk($sformatf("vec%0d_empty", i),     empty,     vt[i].ee);
         chk($sformatf("vec%0d_full", i),      full,      vt[i].ef);
      end

      // Async reset mid-cycle with three entries held.
      step(1'b0, 4'b1100);
      step(1'b0, 4'b0011);
      step(1'b0, 4'b1001);
      chk("pre_rst_empty", empty, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_empty",     empty,     1'b1);
      chk("midrst_full",      full,      1'b0);
      chk("midrst_out",       out,       4'b0000);
      chk("midrst_out_valid", out_valid, 1'b0);
      #2 rst_n = 1'b1;
      step(1'b1, 4'b0000);
      chk("postrst_deq_out_valid", out_valid, 1'b0);
      chk("postrst_deq_empty",     empty,     1'b1);
      chk("postrst_deq_out",       out,       4'b0000);
      model_reset();

      // Randomized ops against the reference model.
      for (int i = 0; i < 600; i++) begin
         logic       d;
         logic [3:0] v;
         if (i == 300) begin
            #2 rst_n = 1'b0;
            #2 rst_n = 1'b1;
            model_reset();
         end
         d = ($urandom_range(0, 99) < 45);
         v = 4'($urandom);
         model_op(d, v);
         step(d, v);
         chk($sformatf("rnd%0d_out", i),       out,       mout);
         chk($sformatf("rnd%0d_out_valid", i), out_valid, mvld);
         chk($sformatf("rnd%0d_empty", i),     empty,     (mq.size() == 0));
         chk($sformatf("rnd%0d_full", i),      full,      (mq.size() == DEPTH));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
